// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the multi-digit BCD keypad calculator.
//   state_e    : calculator FSM states
//   op_e       : latched operator (OP_ADD = 0, OP_SUB = 1)
//   key_e      : decoded kind of a key event
//   SEG_DIGIT  : 7448-style active-high segment patterns for 0..9 (bit0 = a .. bit6 = g)
//   bcd_to_seg : one BCD digit to segments; non-decimal codes are blanked
package bcd_calc_pkg;

    typedef enum logic [1:0] {
        StEntryA,
        StEntryB,
        StCalc,
        StShow
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        KeyDigit,
        KeyAdd,
        KeySub,
        KeyEq
    } key_e;

    // 7448 shapes: 6 has no top bar and 9 has no bottom bar.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        if (d <= 4'd9) begin
            s = SEG_DIGIT[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal correction.
//   a_i, b_i : BCD digits (0..9)
//   cin_i    : carry in
//   sum_o    : BCD sum digit
//   cout_o   : decimal carry out (raw sum above 9)
module bcd_digit_add
    import bcd_calc_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
        adj = raw - 5'd10;
        if (raw > 5'd9) begin
            sum_o  = adj[3:0];
            cout_o = 1'b1;
        end else begin
            sum_o  = raw[3:0];
            cout_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_calc_ndigit.sv
// DIGITS-wide BCD keypad calculator (A+B / A-B), digit-serial through one shared adder.
//   CLK  : clock              CLRb : synchronous active-low reset
//   KEYn : digit keys (low)   ADDn/SUBn/EQn : operator keys (low)
//   seg  : 7 segments per digit, digit 0 in seg[6:0]
//   neg  : shown result is negative (magnitude on seg)
//   ovf  : addition carried out of the MSD
//   busy : calculation in progress
module bcd_calc_ndigit
    import bcd_calc_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  CLRb,
    input  logic [9:0]            KEYn,
    input  logic                  ADDn,
    input  logic                  SUBn,
    input  logic                  EQn,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  neg,
    output logic                  ovf,
    output logic                  busy
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

    // ---------------- key front end ----------------
    logic       any_key;
    logic       any_key_q;
    logic       evt_q;
    key_e       kind_raw, evt_kind_q;
    logic [3:0] digit_raw, evt_digit_q;

    assign any_key = ~(&KEYn) | ~ADDn | ~SUBn | ~EQn;

    always_comb begin
        digit_raw = 4'd0;
        // Ascending scan, so the highest pressed digit wins.
        for (int unsigned i = 0; i < 10; i++) begin
            if (!KEYn[i]) begin
                digit_raw = 4'(i);
            end
        end
        if (!EQn) begin
            kind_raw = KeyEq;
        end else if (!ADDn) begin
            kind_raw = KeyAdd;
        end else if (!SUBn) begin
            kind_raw = KeySub;
        end else begin
            kind_raw = KeyDigit;
        end
    end

    // The decoded event is registered; the FSM acts on it one edge later.
    always_ff @(posedge CLK) begin
        if (!CLRb) begin
            any_key_q   <= 1'b1;  // a key held through reset must be released first
            evt_q       <= 1'b0;
            evt_kind_q  <= KeyDigit;
            evt_digit_q <= 4'd0;
        end else begin
            any_key_q   <= any_key;
            evt_q       <= any_key & ~any_key_q;
            evt_kind_q  <= kind_raw;
            evt_digit_q <= digit_raw;
        end
    end

    // ---------------- calculator state ----------------
    state_e              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, r_q, r_d;
    logic [CW-1:0]       count_q, count_d, idx_q, idx_d;
    logic                carry_q, carry_d, pass2_q, pass2_d;
    op_e                 op_q, op_d;
    logic                neg_q, neg_d, ovf_q, ovf_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [W-1:0]        seg_src;

    logic [3:0] a_dig, b_dig, r_dig;
    logic [3:0] add_x, add_y, add_sum;
    logic       add_cout;

    // Digit currently addressed by the serial pass.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        r_dig = 4'd0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == CW'(k)) begin
                a_dig = a_q[4*k +: 4];
                b_dig = b_q[4*k +: 4];
                r_dig = r_q[4*k +: 4];
            end
        end
    end

    // Pass 1: A + B or A + 9's-complement(B). Pass 2: 9's-complement(R) + 1 gives |A-B|.
    always_comb begin
        if (pass2_q) begin
            add_x = 4'd9 - r_dig;
            add_y = 4'd0;
        end else begin
            add_x = a_dig;
            add_y = (op_q == OP_SUB) ? (4'd9 - b_dig) : b_dig;
        end
    end

    bcd_digit_add u_digit_add (
        .a_i    (add_x),
        .b_i    (add_y),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        count_d = count_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        pass2_d = pass2_q;
        op_d    = op_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StEntryA: begin
                if (evt_q) begin
                    case (evt_kind_q)
                        KeyDigit: begin
                            if (count_q < DIGITS_C) begin
                                a_d     = (a_q << 4) | W'(evt_digit_q);
                                count_d = count_q + CW'(1);
                            end
                        end
                        KeyAdd, KeySub: begin
                            op_d    = (evt_kind_q == KeySub) ? OP_SUB : OP_ADD;
                            b_d     = '0;
                            count_d = '0;
                            state_d = StEntryB;
                        end
                        default: ;
                    endcase
                end
            end

            StEntryB: begin
                if (evt_q) begin
                    case (evt_kind_q)
                        KeyDigit: begin
                            if (count_q < DIGITS_C) begin
                                b_d     = (b_q << 4) | W'(evt_digit_q);
                                count_d = count_q + CW'(1);
                            end
                        end
                        KeyAdd, KeySub: begin
                            op_d = (evt_kind_q == KeySub) ? OP_SUB : OP_ADD;
                        end
                        default: begin
                            idx_d   = '0;
                            carry_d = (op_q == OP_SUB);
                            pass2_d = 1'b0;
                            state_d = StCalc;
                        end
                    endcase
                end
            end

            StCalc: begin
                // Key events are dropped here.
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (idx_q == CW'(k)) begin
                        r_d[4*k +: 4] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (pass2_q) begin
                        neg_d   = 1'b1;
                        state_d = StShow;
                    end else if (op_q == OP_ADD) begin
                        ovf_d   = add_cout;
                        state_d = StShow;
                    end else if (add_cout) begin
                        neg_d   = 1'b0;
                        state_d = StShow;
                    end else begin
                        // A < B: re-complement the result in a second pass.
                        pass2_d = 1'b1;
                        carry_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end

            StShow: begin
                if (evt_q) begin
                    case (evt_kind_q)
                        KeyDigit: begin
                            a_d     = W'(evt_digit_q);
                            b_d     = '0;
                            neg_d   = 1'b0;
                            ovf_d   = 1'b0;
                            count_d = CW'(1);
                            state_d = StEntryA;
                        end
                        KeyAdd, KeySub: begin
                            // Chain only from a result that fits as a plain operand.
                            if (!neg_q && !ovf_q) begin
                                a_d     = r_q;
                                op_d    = (evt_kind_q == KeySub) ? OP_SUB : OP_ADD;
                                b_d     = '0;
                                count_d = '0;
                                state_d = StEntryB;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = StEntryA;
        endcase
    end

    // Display follows the next-state operand so it moves together with the state.
    always_comb begin
        unique case (state_d)
            StEntryA: seg_src = a_d;
            StEntryB: seg_src = b_d;
            StShow:   seg_src = r_d;
            default:  seg_src = '0;
        endcase
        seg_d = seg_q;
        if (state_d != StCalc) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                seg_d[7*k +: 7] = bcd_to_seg(seg_src[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLRb) begin
            state_q <= StEntryA;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            pass2_q <= 1'b0;
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= {DIGITS{SEG_DIGIT[0]}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            pass2_q <= pass2_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
        end
    end

    assign seg  = seg_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StCalc);

endmodule

// File: tb/tb_bcd_calc_ndigit.sv
module tb_bcd_calc_ndigit;
    import bcd_calc_pkg::*;

    localparam int K_ADD = 10;
    localparam int K_SUB = 11;
    localparam int K_EQ  = 12;

    logic        CLK = 1'b0;
    logic        CLRb;
    logic [9:0]  KEYn;
    logic        ADDn, SUBn, EQn;
    logic [13:0] seg;
    logic        neg, ovf, busy;

    int checks   = 0;
    int failures = 0;
    int nbusy, first_busy;

    always #5 CLK = ~CLK;

    bcd_calc_ndigit #(.DIGITS(2)) dut (
        .CLK  (CLK),
        .CLRb (CLRb),
        .KEYn (KEYn),
        .ADDn (ADDn),
        .SUBn (SUBn),
        .EQn  (EQn),
        .seg  (seg),
        .neg  (neg),
        .ovf  (ovf),
        .busy (busy)
    );

    // Hand-written 7448 patterns, tens digit in the upper seven bits.
    function automatic logic [13:0] exp_seg(input int d1, input int d0);
        logic [6:0] t [0:9];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
        return {t[d1], t[d0]};
    endfunction

    task automatic release_keys();
        KEYn = 10'h3FF;
        ADDn = 1'b1;
        SUBn = 1'b1;
        EQn  = 1'b1;
    endtask

    task automatic press_keys(input logic [9:0] dmask, input logic [2:0] ops, input int hold);
        @(negedge CLK);
        KEYn = ~dmask;
        ADDn = ~ops[0];
        SUBn = ~ops[1];
        EQn  = ~ops[2];
        repeat (hold) @(negedge CLK);
        release_keys();
        repeat (3) @(negedge CLK);
    endtask

    task automatic press(input int k);
        logic [9:0] m;
        logic [2:0] o;
        m = '0;
        o = '0;
        if (k < 10) m[k] = 1'b1;
        else o[k-10] = 1'b1;
        press_keys(m, o, 1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        CLRb = 1'b0;
        repeat (2) @(negedge CLK);
        CLRb = 1'b1;
        @(negedge CLK);
    endtask

    // Presses EQ and counts busy cycles within a bounded window.
    task automatic run_eq(output int nb, output int first);
        @(negedge CLK);
        EQn = 1'b0;
        nb = 0;
        first = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (busy) begin
                nb++;
                if (first < 0) first = c;
            end
            EQn = 1'b1;
        end
    endtask

    task automatic test_reset();
        CLRb = 1'b0;
        release_keys();
        repeat (3) @(negedge CLK);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL reset_seg: got %h expected %h", seg, exp_seg(0, 0)); end
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL reset_neg: got %b expected 0", neg); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dut.state_q !== StEntryA) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, StEntryA); end
        // Key held through reset release must not register.
        KEYn[4] = 1'b0;
        repeat (2) @(negedge CLK);
        CLRb = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL held_key_seg: got %h expected %h", seg, exp_seg(0, 0)); end
        release_keys();
        repeat (2) @(negedge CLK);
        press(4);
        checks++; if (seg !== exp_seg(0, 4)) begin failures++; $display("FAIL repress_seg: got %h expected %h", seg, exp_seg(0, 4)); end
    endtask

    task automatic test_add();
        do_reset();
        press(4); press(7);
        checks++; if (seg !== exp_seg(4, 7)) begin failures++; $display("FAIL add_entry_a: got %h expected %h", seg, exp_seg(4, 7)); end
        press(K_ADD);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL add_entry_b_clear: got %h expected %h", seg, exp_seg(0, 0)); end
        press(3); press(8);
        checks++; if (seg !== exp_seg(3, 8)) begin failures++; $display("FAIL add_entry_b: got %h expected %h", seg, exp_seg(3, 8)); end
        run_eq(nbusy, first_busy);
        checks++; if (nbusy !== 2) begin failures++; $display("FAIL add_busy_len: got %0d expected 2", nbusy); end
        checks++; if (first_busy !== 1) begin failures++; $display("FAIL add_busy_start: got %0d expected 1", first_busy); end
        checks++; if (seg !== exp_seg(8, 5)) begin failures++; $display("FAIL add_result: got %h expected %h", seg, exp_seg(8, 5)); end
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL add_neg: got %b expected 0", neg); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL add_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_sub_neg();
        do_reset();
        press(2); press(3); press(K_SUB); press(5); press(8);
        run_eq(nbusy, first_busy);
        checks++; if (nbusy !== 4) begin failures++; $display("FAIL subn_busy_len: got %0d expected 4", nbusy); end
        checks++; if (seg !== exp_seg(3, 5)) begin failures++; $display("FAIL subn_result: got %h expected %h", seg, exp_seg(3, 5)); end
        checks++; if (neg !== 1'b1) begin failures++; $display("FAIL subn_neg: got %b expected 1", neg); end
    endtask

    task automatic test_overflow();
        do_reset();
        press(9); press(9); press(K_ADD); press(0); press(1);
        run_eq(nbusy, first_busy);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL ovf_result: got %h expected %h", seg, exp_seg(0, 0)); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        press(K_ADD);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_add_ignored: got %b expected 1", ovf); end
        checks++; if (dut.state_q !== StShow) begin failures++; $display("FAIL ovf_add_state: got %0d expected %0d", dut.state_q, StShow); end
        press(7);
        checks++; if (seg !== exp_seg(0, 7)) begin failures++; $display("FAIL ovf_new_digit: got %h expected %h", seg, exp_seg(0, 7)); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %b expected 0", ovf); end
    endtask

    task automatic test_entry();
        do_reset();
        press(1); press(2); press(3);
        checks++; if (seg !== exp_seg(1, 2)) begin failures++; $display("FAIL entry_full: got %h expected %h", seg, exp_seg(1, 2)); end
        press_keys(10'b00_0000_1000, 3'b001, 1);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL entry_add_wins: got %h expected %h", seg, exp_seg(0, 0)); end
        press(4);
        run_eq(nbusy, first_busy);
        checks++; if (seg !== exp_seg(1, 6)) begin failures++; $display("FAIL entry_sum: got %h expected %h", seg, exp_seg(1, 6)); end
        do_reset();
        press_keys(10'b00_0010_0000, 3'b000, 20);
        checks++; if (seg !== exp_seg(0, 5)) begin failures++; $display("FAIL entry_hold_once: got %h expected %h", seg, exp_seg(0, 5)); end
        press_keys(10'b00_0100_0100, 3'b000, 1);
        checks++; if (seg !== exp_seg(5, 6)) begin failures++; $display("FAIL entry_high_digit: got %h expected %h", seg, exp_seg(5, 6)); end
    endtask

    task automatic test_chain();
        do_reset();
        press(5); press(0); press(K_SUB); press(2); press(0);
        run_eq(nbusy, first_busy);
        checks++; if (seg !== exp_seg(3, 0)) begin failures++; $display("FAIL chain_first: got %h expected %h", seg, exp_seg(3, 0)); end
        checks++; if (neg !== 1'b0) begin failures++; $display("FAIL chain_neg: got %b expected 0", neg); end
        checks++; if (nbusy !== 2) begin failures++; $display("FAIL chain_busy_len: got %0d expected 2", nbusy); end
        press(K_ADD); press(5);
        run_eq(nbusy, first_busy);
        checks++; if (seg !== exp_seg(3, 5)) begin failures++; $display("FAIL chain_second: got %h expected %h", seg, exp_seg(3, 5)); end
    endtask

    task automatic test_reset_mid_calc();
        do_reset();
        press(9); press(9); press(K_ADD); press(0); press(1);
        @(negedge CLK);
        EQn = 1'b0;
        @(negedge CLK);
        EQn = 1'b1;
        @(negedge CLK);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midcalc_busy: got %b expected 1", busy); end
        CLRb = 1'b0;
        @(negedge CLK);
        checks++; if (seg !== exp_seg(0, 0)) begin failures++; $display("FAIL midcalc_seg: got %h expected %h", seg, exp_seg(0, 0)); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midcalc_busy_clr: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midcalc_ovf: got %b expected 0", ovf); end
        checks++; if (dut.state_q !== StEntryA) begin failures++; $display("FAIL midcalc_state: got %0d expected %0d", dut.state_q, StEntryA); end
        CLRb = 1'b1;
        repeat (4) @(negedge CLK);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midcalc_abandon: got %b expected 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_neg();
        test_overflow();
        test_entry();
        test_chain();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
